// File: rtl/level_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : level_countdown_timer
// Description : Loads a per-level BCD countdown on start and decrements it once
//               per prescaled second; flags expiry to the game FSM.
//               Optional penalty subtractor: define LEVEL_TIMER_PENALTY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module level_countdown_timer #(
    parameter int NUM_DIGITS   = 3,
    parameter int LEVEL_WIDTH  = 8,
    parameter int TICK_DIV     = 50000000,
    parameter int PENALTY_SECS = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LEVEL_WIDTH-1:0]  game_level,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    stop,
    input  logic                    penalty,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    running,
    output logic                    expired,
    output logic                    timeout
);

    localparam int c_DW = 4 * NUM_DIGITS;
    localparam int c_PW = $clog2(TICK_DIV);
    localparam int c_LW = (LEVEL_WIDTH > 4) ? LEVEL_WIDTH : 4;
    localparam logic [c_PW-1:0] c_TICK_LAST = c_PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_HALT    = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [c_DW-1:0]   r_digits, w_digits_nxt;
    logic [c_PW-1:0]   r_presc, w_presc_nxt;
    logic              r_running, r_expired, r_timeout, w_timeout_nxt;
    logic              w_tick, w_pen;
    logic [c_DW-1:0]   w_load, w_dec, w_pen_val;

    function automatic logic [11:0] level_time(input logic [LEVEL_WIDTH-1:0] lvl);
        logic [c_LW-1:0] ext;
        logic [11:0]     t;
        ext = c_LW'(lvl);
        t   = 12'h010;
        if ((ext >> 4) == '0) begin
            case (ext[3:0])
                4'd0:    t = 12'h200;
                4'd1:    t = 12'h100;
                4'd2:    t = 12'h060;
                4'd3:    t = 12'h055;
                4'd4:    t = 12'h050;
                4'd5:    t = 12'h045;
                4'd6:    t = 12'h035;
                4'd7:    t = 12'h030;
                4'd8:    t = 12'h025;
                4'd9:    t = 12'h020;
                4'd10:   t = 12'h015;
                default: t = 12'h010;
            endcase
        end
        return t;
    endfunction

    // Ripple a borrow from digit 0 upward; a zero digit becomes 9 and passes it on.
    function automatic logic [c_DW-1:0] bcd_dec(input logic [c_DW-1:0] v);
        logic [c_DW-1:0] r;
        logic            borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign w_load = c_DW'(level_time(game_level));
    assign w_dec  = bcd_dec(r_digits);
    assign w_tick = (r_state == S_RUN) && !pause && (r_presc == c_TICK_LAST);

`ifdef LEVEL_TIMER_PENALTY_EN
    localparam logic [3:0] c_PEN = 4'(PENALTY_SECS);

    // Anything at or below the penalty saturates to zero.
    function automatic logic [c_DW-1:0] bcd_sub_pen(input logic [c_DW-1:0] v);
        logic [c_DW-1:0] r;
        logic [c_DW-1:0] hi;
        r = '0;
        if (((v >> 4) != '0) || (v[3:0] > c_PEN)) begin
            if (v[3:0] >= c_PEN) begin
                r       = v;
                r[3:0]  = v[3:0] - c_PEN;
            end else begin
                hi = bcd_dec(v >> 4);
                r  = {hi[c_DW-5:0], v[3:0] + (4'd10 - c_PEN)};
            end
        end
        return r;
    endfunction

    assign w_pen     = penalty;
    assign w_pen_val = bcd_sub_pen(r_digits);
`else
    localparam int c_unused_penalty_secs = PENALTY_SECS;
    logic w_unused_penalty;
    assign w_unused_penalty = penalty;
    assign w_pen            = 1'b0;
    assign w_pen_val        = r_digits;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_digits_nxt  = r_digits;
        w_presc_nxt   = r_presc;
        w_timeout_nxt = 1'b0;
        if (start) begin
            w_digits_nxt = w_load;
            w_presc_nxt  = '0;
            w_state_nxt  = S_RUN;
        end else if (r_state == S_RUN) begin
            if (stop) begin
                w_state_nxt = S_HALT;
            end else begin
                if (!pause) begin
                    w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
                end
                // A penalty swallows a coincident tick; the prescaler still wraps.
                if (w_pen) begin
                    w_digits_nxt = w_pen_val;
                    if (w_pen_val == '0) begin
                        w_state_nxt   = S_EXPIRED;
                        w_timeout_nxt = 1'b1;
                    end
                end else if (w_tick) begin
                    w_digits_nxt = w_dec;
                    if (w_dec == '0) begin
                        w_state_nxt   = S_EXPIRED;
                        w_timeout_nxt = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_digits  <= '0;
            r_presc   <= '0;
            r_running <= 1'b0;
            r_expired <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_digits  <= w_digits_nxt;
            r_presc   <= w_presc_nxt;
            r_running <= (w_state_nxt == S_RUN);
            r_expired <= (w_state_nxt == S_EXPIRED);
            r_timeout <= w_timeout_nxt;
        end
    end

    assign digits  = r_digits;
    assign running = r_running;
    assign expired = r_expired;
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_level_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_level_countdown_timer
// Description : Vector table, corner sequences and random stimulus against a
//               seconds-based reference model of level_countdown_timer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_level_countdown_timer;

    localparam int c_TICK_DIV = 4;
    localparam int c_PEN_SECS = 5;
`ifdef LEVEL_TIMER_PENALTY_EN
    localparam bit c_PEN_EN = 1'b1;
`else
    localparam bit c_PEN_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  game_level;
    logic        start, pause, stop, penalty;
    logic [11:0] digits;
    logic        running, expired, timeout;

    int checks   = 0;
    int failures = 0;

    level_countdown_timer #(
        .NUM_DIGITS   (3),
        .LEVEL_WIDTH  (8),
        .TICK_DIV     (c_TICK_DIV),
        .PENALTY_SECS (c_PEN_SECS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .game_level (game_level),
        .start      (start),
        .pause      (pause),
        .stop       (stop),
        .penalty    (penalty),
        .digits     (digits),
        .running    (running),
        .expired    (expired),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: remaining time as an integer count of seconds.
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_EXP = 3;
    int m_secs, m_cnt, m_state;
    bit m_to;

    function automatic int lvl_secs(input logic [7:0] l);
        case (int'(l))
            0:       return 200;
            1:       return 100;
            2:       return 60;
            3:       return 55;
            4:       return 50;
            5:       return 45;
            6:       return 35;
            7:       return 30;
            8:       return 25;
            9:       return 20;
            10:      return 15;
            default: return 10;
        endcase
    endfunction

    function automatic logic [11:0] to_bcd(input int s);
        return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic model_reset();
        m_secs = 0; m_cnt = 0; m_state = M_IDLE; m_to = 1'b0;
    endtask

    task automatic model_step(input bit s, input bit p, input bit st, input bit pn,
                              input logic [7:0] lvl);
        bit tick;
        m_to = 1'b0;
        if (s) begin
            m_secs = lvl_secs(lvl); m_cnt = 0; m_state = M_RUN;
        end else if (m_state == M_RUN) begin
            if (st) begin
                m_state = M_HALT;
            end else begin
                tick = !p && (m_cnt == c_TICK_DIV - 1);
                if (!p) m_cnt = (m_cnt + 1) % c_TICK_DIV;
                if (pn && c_PEN_EN) begin
                    m_secs = (m_secs > c_PEN_SECS) ? m_secs - c_PEN_SECS : 0;
                    if (m_secs == 0) begin m_state = M_EXP; m_to = 1'b1; end
                end else if (tick) begin
                    m_secs = m_secs - 1;
                    if (m_secs == 0) begin m_state = M_EXP; m_to = 1'b1; end
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model_digits", 32'(digits), 32'(to_bcd(m_secs)));
        chk("model_flags", {29'd0, running, expired, timeout},
            {29'd0, m_state == M_RUN, m_state == M_EXP, m_to});
    endtask

    task automatic cyc(input bit s, input bit p, input bit st, input bit pn,
                       input logic [7:0] lvl);
        start = s; pause = p; stop = st; penalty = pn; game_level = lvl;
        @(posedge clk);
        model_step(s, p, st, pn, lvl);
        #1;
        check_model();
        start = 1'b0; pause = 1'b0; stop = 1'b0; penalty = 1'b0;
    endtask

    task automatic quiet(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    typedef struct {
        bit          s, p, st, pn;
        logic [7:0]  lvl;
        int          n;
        logic [11:0] d;
        bit          run, exp;
    } vec_t;

    vec_t vecs[18];
    int   tcount;

    initial begin
        vecs[0]  = '{0, 0, 0, 0, 8'd0,   1,  12'h000, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 8'd0,   1,  12'h200, 1, 0};
        vecs[2]  = '{0, 0, 0, 0, 8'd0,   4,  12'h199, 1, 0};
        vecs[3]  = '{0, 0, 0, 0, 8'd0,   4,  12'h198, 1, 0};
        vecs[4]  = '{1, 0, 0, 0, 8'd2,   1,  12'h060, 1, 0};
        vecs[5]  = '{0, 0, 0, 0, 8'd0,   4,  12'h059, 1, 0};
        vecs[6]  = '{1, 0, 0, 0, 8'd200, 1,  12'h010, 1, 0};
        vecs[7]  = '{0, 0, 0, 0, 8'd0,   2,  12'h010, 1, 0};
        vecs[8]  = '{0, 1, 0, 0, 8'd0,   10, 12'h010, 1, 0};
        vecs[9]  = '{0, 0, 0, 0, 8'd0,   1,  12'h010, 1, 0};
        vecs[10] = '{0, 0, 0, 0, 8'd0,   1,  12'h009, 1, 0};
        vecs[11] = '{0, 0, 1, 0, 8'd0,   1,  12'h009, 0, 0};
        vecs[12] = '{0, 0, 0, 0, 8'd0,   25, 12'h009, 0, 0};
        vecs[13] = '{1, 0, 0, 0, 8'd1,   1,  12'h100, 1, 0};
        vecs[14] = '{1, 0, 1, 0, 8'd9,   1,  12'h020, 1, 0};
        vecs[15] = '{0, 0, 0, 0, 8'd0,   3,  12'h020, 1, 0};
        vecs[16] = '{0, 0, 1, 0, 8'd0,   1,  12'h020, 0, 0};
        vecs[17] = '{0, 0, 0, 0, 8'd0,   4,  12'h020, 0, 0};

        rst_n = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0; penalty = 1'b0;
        game_level = 8'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_digits", 32'(digits), 32'h0);
        chk("reset_flags", {29'd0, running, expired, timeout}, 32'h0);
        #3 rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            cyc(vecs[i].s, vecs[i].p, vecs[i].st, vecs[i].pn, vecs[i].lvl);
            for (int k = 1; k < vecs[i].n; k++) cyc(1'b0, vecs[i].p, 1'b0, 1'b0, 8'd0);
            chk($sformatf("vec%0d_digits", i), 32'(digits), 32'(vecs[i].d));
            chk($sformatf("vec%0d_flags", i), {30'd0, running, expired},
                {30'd0, vecs[i].run, vecs[i].exp});
        end

        // Expiry from level 10: one timeout pulse, then hold at zero.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd10);
        chk("lvl10_load", 32'(digits), 32'h015);
        tcount = 0;
        for (int k = 0; k < 75; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
            if (timeout) begin
                tcount++;
                chk("expire_digits", 32'(digits), 32'h0);
                chk("expire_flags", {30'd0, running, expired}, 32'h1);
            end
        end
        chk("timeout_pulses", 32'(tcount), 32'd1);
        chk("expired_hold", {20'd0, digits, 2'd0, expired, timeout}, 32'h2);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
        chk("restart_from_expired", {19'd0, digits, running}, {19'd0, 12'h055, 1'b1});

        // Penalty: active only when the macro is defined.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd10);
        quiet(12);
        chk("pen_pre", 32'(digits), 32'h012);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        chk("pen_first", 32'(digits), c_PEN_EN ? 32'h007 : 32'h012);
`ifdef LEVEL_TIMER_PENALTY_EN
        quiet(16);
        chk("pen_pre2", 32'(digits), 32'h003);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        chk("pen_saturate", {20'd0, digits, 1'b0, running, expired, timeout}, 32'h3);
`endif

        // Asynchronous reset mid-count at 037.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
        quiet(32);
        chk("pre_reset_digits", 32'(digits), 32'h037);
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset_digits", 32'(digits), 32'h0);
        chk("async_reset_flags", {29'd0, running, expired, timeout}, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        quiet(12);
        chk("idle_after_reset", {19'd0, digits, running}, 32'h0);

        // Random stimulus against the model.
        for (int k = 0; k < 3000; k++) begin
            logic [7:0] lvl;
            lvl = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                              : 8'($urandom_range(0, 11));
            cyc($urandom_range(0, 149) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0, lvl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
